dmi_avalon_master: RTL and testbench



---
 rtl/dmi_avalon_master_if.sv | 64 ++++++
 rtl/dmi_avalon_master.sv | 207 ++++++++++++++++++++
 tb/tb_dmi_avalon_master.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmi_avalon_master_if.sv
// -----------------------------------------------------------------------------
// dmi_avalon_master_if
//   Bundles the DMI request/response channel and the Avalon-MM master port
//   driven by dmi_avalon_master.
//
//   DMI request  : dmi_req_i {addr[6:0], op[1:0], data[31:0]}, dmi_req_valid_i,
//                  dmi_req_ready_o
//   DMI response : dmi_resp_o {data[31:0], resp[1:0]}, dmi_resp_valid_o,
//                  dmi_resp_ready_i
//   Avalon-MM    : avalon_m_address/read/write/writedata/byteenable (out),
//                  avalon_m_waitrequest_n/readdata/readdatavalid/response (in)
//
//   modport master : the dmi_avalon_master side
//   modport slave  : the DTM host plus the Avalon fabric side
// -----------------------------------------------------------------------------
interface dmi_avalon_master_if;

    typedef struct packed {
        logic [6:0]  addr;
        logic [1:0]  op;
        logic [31:0] data;
    } dmi_req_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } dmi_resp_t;

    dmi_req_t    dmi_req_i;
    logic        dmi_req_valid_i;
    logic        dmi_req_ready_o;
    dmi_resp_t   dmi_resp_o;
    logic        dmi_resp_valid_o;
    logic        dmi_resp_ready_i;

    logic [31:0] avalon_m_address;
    logic        avalon_m_read;
    logic        avalon_m_write;
    logic [31:0] avalon_m_writedata;
    logic [3:0]  avalon_m_byteenable;
    logic        avalon_m_waitrequest_n;
    logic [31:0] avalon_m_readdata;
    logic        avalon_m_readdatavalid;
    logic [1:0]  avalon_m_response;

    modport master (
        input  dmi_req_i, dmi_req_valid_i, dmi_resp_ready_i,
               avalon_m_waitrequest_n, avalon_m_readdata,
               avalon_m_readdatavalid, avalon_m_response,
        output dmi_req_ready_o, dmi_resp_o, dmi_resp_valid_o,
               avalon_m_address, avalon_m_read, avalon_m_write,
               avalon_m_writedata, avalon_m_byteenable
    );

    modport slave (
        output dmi_req_i, dmi_req_valid_i, dmi_resp_ready_i,
               avalon_m_waitrequest_n, avalon_m_readdata,
               avalon_m_readdatavalid, avalon_m_response,
        input  dmi_req_ready_o, dmi_resp_o, dmi_resp_valid_o,
               avalon_m_address, avalon_m_read, avalon_m_write,
               avalon_m_writedata, avalon_m_byteenable
    );

endinterface

// File: rtl/dmi_avalon_master.sv
// -----------------------------------------------------------------------------
// dmi_avalon_master
//   DMI responder giving a debug host system-bus access through an Avalon-MM
//   master. Register window (DMI word address):
//     0x00 ADDR  byte address of the next bus access ([1:0] forced to 0)
//     0x01 DATA  write -> blocking bus write; read -> current DATA, then an
//                optional background bus read (autoread)
//     0x02 CTRL  [0] autoinc, [1] autoread, [8] busy (RO), [12] err (W1C),
//                [13] timeout (W1C, timeout build only)
//
//   Ports : clk_i, rst_i (async, active high), bus (dmi_avalon_master_if.master)
//   Params: ADDR_RESET     reset value of ADDR
//           TIMEOUT_CYCLES bus-cycle abort limit (timeout build only)
//   Macro : DMI_AVALON_TIMEOUT_EN enables the bus timeout counter.
// -----------------------------------------------------------------------------
module dmi_avalon_master #(
    parameter logic [31:0] ADDR_RESET     = 32'h0,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    dmi_avalon_master_if.master        bus
);

    typedef enum logic [1:0] {IDLE, BUS_REQ, BUS_RD, RESP} state_t;

    localparam logic [6:0] A_ADDR = 7'h00;
    localparam logic [6:0] A_DATA = 7'h01;
    localparam logic [6:0] A_CTRL = 7'h02;
    localparam logic [1:0] OP_NOP = 2'd0;
    localparam logic [1:0] OP_RD  = 2'd1;
    localparam logic [1:0] OP_WR  = 2'd2;

    state_t      r_state, w_next;
    logic [31:0] r_addr, r_data, r_resp_data;
    logic [1:0]  r_resp_code;
    logic        r_autoinc, r_autoread, r_err;
    logic        r_is_write;   // current bus op is the blocking DATA write
    logic        r_bg;         // current bus op is a background read
    logic        r_bg_pend;    // background read starts after response handshake

    logic        w_accept, w_cmd_done, w_rd_done, w_resp_done;
    logic        w_start_bus, w_ctrl_wr, w_busy, w_abort, w_timeout_bit;
    logic [31:0] w_ctrl;

    assign w_start_bus = (bus.dmi_req_i.op == OP_WR) && (bus.dmi_req_i.addr == A_DATA) && !r_err;
    assign w_ctrl_wr   = w_accept && (bus.dmi_req_i.op == OP_WR) && (bus.dmi_req_i.addr == A_CTRL);
    assign w_busy      = (r_state == BUS_REQ) || (r_state == BUS_RD) || r_bg_pend;
    assign w_ctrl      = {18'b0, w_timeout_bit, r_err, 3'b0, w_busy, 6'b0, r_autoread, r_autoinc};

`ifdef DMI_AVALON_TIMEOUT_EN
    logic [31:0] r_cnt;
    logic        r_timeout;

    // Abort only when the awaited event has not arrived in the limit cycle.
    assign w_abort = (r_cnt == 32'(TIMEOUT_CYCLES - 1)) &&
                     (((r_state == BUS_REQ) && !bus.avalon_m_waitrequest_n) ||
                      ((r_state == BUS_RD)  && !bus.avalon_m_readdatavalid));
    assign w_timeout_bit = r_timeout;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (((r_state == BUS_REQ) || (r_state == BUS_RD)) && (w_next == r_state))
                r_cnt <= r_cnt + 32'd1;
            else
                r_cnt <= '0;
            if (w_abort)
                r_timeout <= 1'b1;
            else if (w_ctrl_wr && bus.dmi_req_i.data[13])
                r_timeout <= 1'b0;
        end
    end
`else
    assign w_abort       = 1'b0;
    assign w_timeout_bit = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_accept    = 1'b0;
        w_cmd_done  = 1'b0;
        w_rd_done   = 1'b0;
        w_resp_done = 1'b0;
        case (r_state)
            IDLE: if (bus.dmi_req_valid_i) begin
                w_accept = 1'b1;
                w_next   = w_start_bus ? BUS_REQ : RESP;
            end
            BUS_REQ: if (bus.avalon_m_waitrequest_n) begin
                w_cmd_done = 1'b1;
                w_next     = r_is_write ? RESP : BUS_RD;
            end else if (w_abort) begin
                w_next = r_bg ? IDLE : RESP;
            end
            BUS_RD: if (bus.avalon_m_readdatavalid) begin
                w_rd_done = 1'b1;
                w_next    = IDLE;
            end else if (w_abort) begin
                w_next = IDLE;
            end
            RESP: if (bus.dmi_resp_ready_i) begin
                w_resp_done = 1'b1;
                w_next      = r_bg_pend ? BUS_REQ : IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    assign bus.dmi_req_ready_o     = (r_state == IDLE);
    assign bus.dmi_resp_valid_o    = (r_state == RESP);
    assign bus.dmi_resp_o          = {r_resp_data, r_resp_code};
    assign bus.avalon_m_address    = r_addr;
    assign bus.avalon_m_read       = (r_state == BUS_REQ) && !r_is_write;
    assign bus.avalon_m_write      = (r_state == BUS_REQ) && r_is_write;
    assign bus.avalon_m_writedata  = r_data;
    assign bus.avalon_m_byteenable = 4'hF;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_addr      <= {ADDR_RESET[31:2], 2'b00};
            r_data      <= '0;
            r_resp_data <= '0;
            r_resp_code <= '0;
            r_autoinc   <= 1'b0;
            r_autoread  <= 1'b0;
            r_err       <= 1'b0;
            r_is_write  <= 1'b0;
            r_bg        <= 1'b0;
            r_bg_pend   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_resp_data <= '0;
                r_resp_code <= 2'd0;
                r_is_write  <= 1'b0;
                r_bg        <= 1'b0;
                r_bg_pend   <= 1'b0;
                if (bus.dmi_req_i.op == OP_NOP) begin
                    r_resp_code <= 2'd0;
                end else if (bus.dmi_req_i.op != OP_RD && bus.dmi_req_i.op != OP_WR) begin
                    r_resp_code <= 2'd2;
                end else begin
                    case (bus.dmi_req_i.addr)
                        A_ADDR: if (bus.dmi_req_i.op == OP_RD) begin
                            r_resp_data <= r_addr;
                        end else begin
                            r_addr    <= {bus.dmi_req_i.data[31:2], 2'b00};
                            r_bg_pend <= r_autoread && !r_err;
                        end
                        A_DATA: if (r_err) begin
                            r_resp_code <= 2'd2;
                        end else if (bus.dmi_req_i.op == OP_RD) begin
                            r_resp_data <= r_data;
                            r_bg_pend   <= r_autoread;
                        end else begin
                            r_data     <= bus.dmi_req_i.data;
                            r_is_write <= 1'b1;
                        end
                        A_CTRL: if (bus.dmi_req_i.op == OP_RD) begin
                            r_resp_data <= w_ctrl;
                        end else begin
                            r_autoinc  <= bus.dmi_req_i.data[0];
                            r_autoread <= bus.dmi_req_i.data[1];
                            if (bus.dmi_req_i.data[12]) r_err <= 1'b0;
                        end
                        default: r_resp_code <= 2'd2;
                    endcase
                end
            end

            if (w_resp_done && r_bg_pend) begin
                r_bg      <= 1'b1;
                r_is_write <= 1'b0;
                r_bg_pend <= 1'b0;
            end

            // Write completion status is taken with the command acceptance.
            if (w_cmd_done && r_is_write) begin
                if (bus.avalon_m_response != 2'd0) begin
                    r_err       <= 1'b1;
                    r_resp_code <= 2'd2;
                end else if (r_autoinc) begin
                    r_addr <= r_addr + 32'd4;
                end
            end

            if (w_rd_done) begin
                r_data <= bus.avalon_m_readdata;
                if (bus.avalon_m_response != 2'd0) r_err  <= 1'b1;
                else if (r_autoinc)                r_addr <= r_addr + 32'd4;
            end

            if (w_abort) begin
                r_err <= 1'b1;
                if (!r_bg) r_resp_code <= 2'd2;
            end
        end
    end

endmodule

// File: tb/tb_dmi_avalon_master.sv
// -----------------------------------------------------------------------------
// tb_dmi_avalon_master
//   Directed bench for dmi_avalon_master. Stimulus pushes expected DMI
//   responses and expected Avalon commands into queues; a response monitor and
//   an Avalon slave model pop and compare as the DUT presents them.
// -----------------------------------------------------------------------------
module tb_dmi_avalon_master;

    localparam logic [6:0] A_ADDR = 7'h00;
    localparam logic [6:0] A_DATA = 7'h01;
    localparam logic [6:0] A_CTRL = 7'h02;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        string       name;
    } resp_exp_t;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int unsigned cycles;
    } bus_exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dmi_avalon_master_if bus();

    dmi_avalon_master #(
        .ADDR_RESET(32'h0)
`ifdef DMI_AVALON_TIMEOUT_EN
        , .TIMEOUT_CYCLES(16)
`endif
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int          checks = 0;
    int          errors = 0;
    resp_exp_t   sb_q[$];
    bus_exp_t    bus_q[$];
    logic [31:0] rd_q[$];

    int unsigned wr_wait  = 0;
    int unsigned wait_cnt = 0;
    int unsigned hold     = 0;
    logic        pend_rd  = 1'b0;
    logic        no_rdv   = 1'b0;
    logic        bad_hold = 1'b0;
    logic [1:0]  bus_resp = 2'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // DMI response monitor
    initial begin
        resp_exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus.dmi_resp_valid_o && bus.dmi_resp_ready_i) begin
                if (sb_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_resp actual=%h required=none", bus.dmi_resp_o.data);
                end else begin
                    e = sb_q.pop_front();
                    chk({e.name, "_data"}, bus.dmi_resp_o.data, e.data);
                    chk({e.name, "_resp"}, 32'(bus.dmi_resp_o.resp), 32'(e.resp));
                end
            end
        end
    end

    // Avalon slave model and command checker
    initial begin
        bus_exp_t b;
        forever begin
            @(negedge clk);
            if (rst) begin
                wait_cnt = 0; hold = 0; pend_rd = 1'b0; bad_hold = 1'b0;
                bus.avalon_m_readdatavalid = 1'b0;
                bus.avalon_m_waitrequest_n = 1'b1;
            end else begin
                bus.avalon_m_readdatavalid = 1'b0;
                bus.avalon_m_response      = bus_resp;
                if (pend_rd) begin
                    pend_rd = 1'b0;
                    if (!no_rdv) begin
                        bus.avalon_m_readdatavalid = 1'b1;
                        bus.avalon_m_readdata = (rd_q.size() != 0) ? rd_q.pop_front() : 32'hBAD0BAD0;
                    end
                end
                if (bus.avalon_m_read || bus.avalon_m_write) begin
                    if (bus_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_bus actual=addr %h wr %b required=no access",
                                 bus.avalon_m_address, bus.avalon_m_write);
                        bus.avalon_m_waitrequest_n = 1'b1;
                    end else begin
                        hold++;
                        if (bus.avalon_m_write !== bus_q[0].wr || bus.avalon_m_read !== !bus_q[0].wr ||
                            bus.avalon_m_address !== bus_q[0].addr ||
                            (bus_q[0].wr && bus.avalon_m_writedata !== bus_q[0].wdata) ||
                            bus.dmi_req_ready_o !== 1'b0)
                            bad_hold = 1'b1;
                        if (wait_cnt < wr_wait) begin
                            bus.avalon_m_waitrequest_n = 1'b0;
                            wait_cnt++;
                        end else begin
                            bus.avalon_m_waitrequest_n = 1'b1;
                            wait_cnt = 0;
                            b = bus_q.pop_front();
                            chk("bus_write", 32'(bus.avalon_m_write), 32'(b.wr));
                            chk("bus_addr", bus.avalon_m_address, b.addr);
                            if (b.wr) chk("bus_wdata", bus.avalon_m_writedata, b.wdata);
                            chk("bus_byteen", 32'(bus.avalon_m_byteenable), 32'hF);
                            chk("bus_hold_cycles", hold, b.cycles);
                            chk("bus_hold_stable", 32'(bad_hold), 32'd0);
                            if (!b.wr) pend_rd = 1'b1;
                            hold = 0;
                            bad_hold = 1'b0;
                        end
                    end
                end else begin
                    bus.avalon_m_waitrequest_n = 1'b1;
                end
            end
        end
    end

    task automatic dmi(input logic [6:0] a, input logic [1:0] op, input logic [31:0] d,
                       input logic [31:0] ed, input logic [1:0] er, input string name);
        int n;
        sb_q.push_back('{ed, er, name});
        n = 0;
        @(negedge clk);
        while (bus.dmi_req_ready_o !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (bus.dmi_req_ready_o !== 1'b1) begin
            checks++; errors++;
            $display("FAIL %s_ready_timeout actual=0 required=1", name);
            sb_q.delete();
            return;
        end
        bus.dmi_req_i       = {a, op, d};
        bus.dmi_req_valid_i = 1'b1;
        @(posedge clk);
        #1 bus.dmi_req_valid_i = 1'b0;
        n = 0;
        while (sb_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL %s_resp_timeout actual=none required=response", name);
            sb_q.delete();
        end
    endtask

    task automatic rd(input logic [6:0] a, input logic [31:0] ed, input logic [1:0] er, input string name);
        dmi(a, 2'd1, 32'h0, ed, er, name);
    endtask

    task automatic wr(input logic [6:0] a, input logic [31:0] d, input logic [1:0] er, input string name);
        dmi(a, 2'd2, d, 32'h0, er, name);
    endtask

    task automatic exp_bus(input logic w, input logic [31:0] a, input logic [31:0] d, input int unsigned c);
        bus_q.push_back('{w, a, d, c});
    endtask

    initial begin
        rst = 1'b1;
        bus.dmi_req_i              = '0;
        bus.dmi_req_valid_i        = 1'b0;
        bus.dmi_resp_ready_i       = 1'b1;
        bus.avalon_m_waitrequest_n = 1'b1;
        bus.avalon_m_readdata      = '0;
        bus.avalon_m_readdatavalid = 1'b0;
        bus.avalon_m_response      = 2'd0;
        repeat (3) @(negedge clk);
        chk("rst_ready",      32'(bus.dmi_req_ready_o),     32'd1);
        chk("rst_resp_valid", 32'(bus.dmi_resp_valid_o),    32'd0);
        chk("rst_read",       32'(bus.avalon_m_read),       32'd0);
        chk("rst_write",      32'(bus.avalon_m_write),      32'd0);
        chk("rst_address",    bus.avalon_m_address,         32'h0);
        chk("rst_byteen",     32'(bus.avalon_m_byteenable), 32'hF);
        rst = 1'b0;
        rd(A_ADDR, 32'h0, 2'd0, "rst_addr_reg");
        rd(A_DATA, 32'h0, 2'd0, "rst_data_reg");
        rd(A_CTRL, 32'h0, 2'd0, "rst_ctrl_reg");

        // Blocking write with autoinc
        wr(A_CTRL, 32'h1, 2'd0, "t1_ctrl");
        wr(A_ADDR, 32'h1000, 2'd0, "t1_addr");
        exp_bus(1'b1, 32'h1000, 32'hDEADBEEF, 1);
        wr(A_DATA, 32'hDEADBEEF, 2'd0, "t1_data_wr");
        rd(A_ADDR, 32'h1004, 2'd0, "t1_addr_inc");

        // Autoread + autoinc background reads
        wr(A_CTRL, 32'h3, 2'd0, "t2_ctrl");
        exp_bus(1'b0, 32'h2000, 32'h0, 1); rd_q.push_back(32'h11111111);
        wr(A_ADDR, 32'h2000, 2'd0, "t2_addr");
        exp_bus(1'b0, 32'h2004, 32'h0, 1); rd_q.push_back(32'h22222222);
        rd(A_DATA, 32'h11111111, 2'd0, "t2_data_rd1");
        exp_bus(1'b0, 32'h2008, 32'h0, 1); rd_q.push_back(32'h33333333);
        rd(A_DATA, 32'h22222222, 2'd0, "t2_data_rd2");
        rd(A_ADDR, 32'h200C, 2'd0, "t2_addr_final");
        rd(A_CTRL, 32'h3, 2'd0, "t2_ctrl_rd");

        // Write held by waitrequest_n low for 5 cycles
        wr(A_CTRL, 32'h0, 2'd0, "t3_ctrl");
        wr_wait = 5;
        exp_bus(1'b1, 32'h200C, 32'hCAFEF00D, 6);
        wr(A_DATA, 32'hCAFEF00D, 2'd0, "t3_data_wr");
        wr_wait = 0;
        rd(A_ADDR, 32'h200C, 2'd0, "t3_addr_noinc");
        rd(A_DATA, 32'hCAFEF00D, 2'd0, "t3_data_rd");

        // Bus error on write, error lockout, W1C clear
        wr(A_CTRL, 32'h1, 2'd0, "t4_ctrl");
        wr(A_ADDR, 32'h3000, 2'd0, "t4_addr");
        bus_resp = 2'd2;
        exp_bus(1'b1, 32'h3000, 32'h12345678, 1);
        wr(A_DATA, 32'h12345678, 2'd2, "t4_data_err");
        bus_resp = 2'd0;
        rd(A_CTRL, 32'h1001, 2'd0, "t4_ctrl_err");
        wr(A_DATA, 32'h55, 2'd2, "t4_locked_wr");
        rd(A_DATA, 32'h0, 2'd2, "t4_locked_rd");
        rd(A_ADDR, 32'h3000, 2'd0, "t4_addr_noinc");
        wr(A_CTRL, 32'h1000, 2'd0, "t4_clear");
        rd(A_CTRL, 32'h0, 2'd0, "t4_ctrl_clr");

        // Illegal op / address, NOP, timeout bit write
        dmi(A_ADDR, 2'd3, 32'h0, 32'h0, 2'd2, "t5_op3");
        rd(7'h05, 32'h0, 2'd2, "t5_bad_rd");
        wr(7'h05, 32'h1, 2'd2, "t5_bad_wr");
        dmi(A_DATA, 2'd0, 32'h0, 32'h0, 2'd0, "t5_nop");
        rd(A_ADDR, 32'h3000, 2'd0, "t5_addr_kept");
        wr(A_CTRL, 32'h2000, 2'd0, "t5_ctrl_wr");
        rd(A_CTRL, 32'h0, 2'd0, "t5_ctrl_rd");

        // Background read with bus error
        wr(A_CTRL, 32'h2, 2'd0, "t6_ctrl");
        bus_resp = 2'd2;
        exp_bus(1'b0, 32'h3000, 32'h0, 1); rd_q.push_back(32'h00000077);
        rd(A_DATA, 32'h12345678, 2'd0, "t6_data_rd");
        rd(A_CTRL, 32'h1002, 2'd0, "t6_ctrl_err");
        bus_resp = 2'd0;
        wr(A_CTRL, 32'h1000, 2'd0, "t6_clear");
        rd(A_DATA, 32'h77, 2'd0, "t6_data_latched");
        rd(A_ADDR, 32'h3000, 2'd0, "t6_addr");

`ifdef DMI_AVALON_TIMEOUT_EN
        // Background read that never returns data
        wr(A_CTRL, 32'h2, 2'd0, "t7_ctrl");
        no_rdv = 1'b1;
        exp_bus(1'b0, 32'h3000, 32'h0, 1);
        rd(A_DATA, 32'h77, 2'd0, "t7_data_rd");
        rd(A_CTRL, 32'h3002, 2'd0, "t7_ctrl_to");
        no_rdv = 1'b0;
        rd(A_DATA, 32'h0, 2'd2, "t7_locked_rd");
        wr(A_CTRL, 32'h3000, 2'd0, "t7_clear");
        rd(A_CTRL, 32'h0, 2'd0, "t7_ctrl_clr");
        rd(A_DATA, 32'h77, 2'd0, "t7_data_kept");
`endif

        chk("bus_queue_drained", 32'(bus_q.size()), 32'd0);

        // Reset in the middle of a stalled write
        wr(A_ADDR, 32'h4000, 2'd0, "t8_addr");
        wr_wait = 50;
        exp_bus(1'b1, 32'h4000, 32'h0000ABCD, 99);
        @(negedge clk);
        bus.dmi_req_i       = {A_DATA, 2'd2, 32'h0000ABCD};
        bus.dmi_req_valid_i = 1'b1;
        @(posedge clk);
        #1 bus.dmi_req_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("t8_write_active", 32'(bus.avalon_m_write), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("t8_rst_write", 32'(bus.avalon_m_write), 32'd0);
        chk("t8_rst_read",  32'(bus.avalon_m_read),  32'd0);
        bus_q.delete();
        wr_wait = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        rd(A_ADDR, 32'h0, 2'd0, "t8_addr_reset");

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
